data_port_arbiter: RTL and testbench
====================================

Name: data_port_arbiter

Overview:
- Shares the single RAM/memory-mapped data port (enable, write, DATA_address, DATA_out, DATA_in) between two requesters.
  - Master 0 is the CPU data interface.
  - Master 1 is a DMA/debug loader.
- Provides round-robin arbitration, an optional bus lock with a bounded lock timeout, and read-return sequencing for a fixed-latency slave.
- Sits between the requesters and the RAM_mem / testbench address decode.

Parameters:
- RD_LATENCY, 1: cycles from a read grant to slave read data valid on DATA_in; legal range 1..4.
- LOCK_MAX, 16: maximum consecutive grants to a locking master before priority is forced to the other master.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1 each  access request; held until granted.
- m0_lock, m1_lock  in  1 each  request to keep ownership for back-to-back accesses.
- m0_we, m1_we  in  4 each  byte write enables; 0 means read.
- m0_addr, m1_addr  in  32 each  byte address.
- m0_wdata, m1_wdata  in  32 each  write data.
- m0_gnt, m1_gnt  out  1 each  access accepted this cycle.
- m0_rvalid, m1_rvalid  out  1 each  one-cycle read-data-valid pulse.
- m0_rdata, m1_rdata  out  32 each  read data; valid when the matching rvalid is 1.
- enable  out  1  slave access strobe.
- write  out  4  slave byte write enables.
- DATA_address  out  32  slave address.
- DATA_out  out  32  slave write data.
- DATA_in  in  32  slave read data.

Behaviour:
- Reset values (reset=0, asynchronous):
  - All gnt, rvalid, enable and write outputs are 0.
  - rdata, DATA_address and DATA_out are 0.
  - State is IDLE, last_grant=1, lock_cnt=0, rd_cnt=0.
- States:
  - IDLE: a grant is possible this cycle.
  - WAIT_RD: read outstanding; no grants.
- Arbitration (IDLE only):
  - m*_gnt is combinational from the req inputs and registered state.
  - At most one gnt is asserted per cycle.
- Winner selection:
  - Only one master requesting: that master wins.
  - Both requesting and the owner (=last_grant) has lock=1 and lock_cnt<LOCK_MAX: the owner wins.
  - Both requesting otherwise: the master != last_grant wins.
- Granted cycle:
  - enable=1.
  - write, DATA_address and DATA_out equal the winner's we, addr and wdata.
  - When no gnt: enable=0, write=0, DATA_address=0, DATA_out=0.
- Register updates on a grant:
  - last_grant <= winner.
  - lock_cnt <= lock_cnt+1 if the winner equals the previous last_grant and its lock=1; otherwise lock_cnt <= 1 if its lock=1, else 0.
  - lock_cnt saturates at LOCK_MAX.
- Write grant (we!=0):
  - Completes in the grant cycle; there is no rvalid.
  - State stays IDLE, so a new grant is possible the next cycle.
- Read grant (we==0):
  - State <= WAIT_RD, rd_cnt <= RD_LATENCY, owner tag registered.
  - rd_cnt decrements each cycle.
  - In the cycle rd_cnt reaches 1, DATA_in is captured into the owner's rdata register.
  - The owner's rvalid=1 for exactly the following cycle.
  - State returns to IDLE in that same rvalid cycle, so a new grant may coincide with rvalid.
- Read latency: grant at cycle T gives rvalid at cycle T+RD_LATENCY+1.
- rdata of the non-owner is unchanged by a read; rdata holds its value until the next read for that master.
- Lock release:
  - The owner deasserting lock, or the other master winning, clears lock_cnt.
  - Reaching LOCK_MAX forces exactly one arbitration to the other master if it requests; otherwise the owner continues and lock_cnt stays saturated.
- Requests arriving during WAIT_RD are held by the master and arbitrated in the IDLE cycle after the read returns.
- Reset asserted in WAIT_RD:
  - The pending read is dropped and no rvalid is produced.
  - After reset release, the first simultaneous request goes to m0.
- A master must keep req, we, addr and wdata stable until gnt.
- A requester deasserting req before gnt is legal; the arbiter takes no action.

Test Plan:
- Reset, then m0 write we=4'hF addr=0x100 wdata=0xDEADBEEF -> m0_gnt=1, enable=1, write=4'hF, DATA_address=0x100 in the same cycle; no rvalid.
- Both request reads simultaneously after reset, RD_LATENCY=1, slave returns 0x11 then 0x22:
  - m0 granted at T, m0_rvalid at T+2 with rdata=0x11.
  - m1 granted at T+2, m1_rvalid at T+4 with rdata=0x22.
- Both hold continuous write requests without lock -> grants alternate m0, m1, m0, m1 on consecutive cycles.
- m1 holds lock=1 with back-to-back writes while m0 requests, LOCK_MAX=16 -> m1 gets 16 consecutive grants, m0 gets the 17th, then m1 resumes.
- RD_LATENCY=3, m0 read at T and m1 request at T+1 -> m1_gnt stays 0 through T+3; m0_rvalid=1 and m1_gnt=1 at T+4.
- Reset driven low at T+1 after an m0 read grant at T -> no m0_rvalid ever; all outputs are 0 during reset; state is IDLE after release.

Source files
------------

// File: rtl/data_port_arbiter.sv
// data_port_arbiter
//   Shares one fixed-latency RAM / memory-mapped data port between two masters:
//   master 0 (CPU data side) and master 1 (DMA / debug loader).
//   Round-robin arbitration with an optional bounded bus lock, and read-return
//   sequencing that routes slave read data back to the master that issued it.
//
// Ports
//   clk, reset                     clock (rising edge), async active-low reset
//   m*_req / m*_lock               request, ask to keep ownership
//   m*_we / m*_addr / m*_wdata     byte write enables (0 = read), address, data
//   m*_gnt                         access accepted this cycle (combinational)
//   m*_rvalid / m*_rdata           one-cycle read-return pulse and held read data
//   enable / write / DATA_address / DATA_out   slave strobe, byte enables, addr, wdata
//   DATA_in                        slave read data, valid RD_LATENCY cycles after grant
module data_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [3:0]  m0_we,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        enable,
  output logic [3:0]  write,
  output logic [31:0] DATA_address,
  output logic [31:0] DATA_out,
  input  logic [31:0] DATA_in
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(LOCK_MAX);
  localparam logic [LCW-1:0] LOCK_ONE_C = {{(LCW-1){1'b0}}, 1'b1};
  localparam logic [2:0]     RD_LAT_C   = 3'(RD_LATENCY);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [2:0]      rd_cnt_q, rd_cnt_d;
  logic            rd_owner_q, rd_owner_d;
  logic            m0_rvalid_q, m0_rvalid_d;
  logic            m1_rvalid_q, m1_rvalid_d;
  logic [31:0]     m0_rdata_q, m0_rdata_d;
  logic [31:0]     m1_rdata_q, m1_rdata_d;

  logic            win_valid_s;
  logic            win_s;
  logic            owner_lock_s;
  logic            win_lock_s;
  logic [3:0]      win_we_s;
  logic [31:0]     win_addr_s;
  logic [31:0]     win_wdata_s;

  // Winner selection; gated by reset so no grant leaks out while held in reset.
  always_comb begin
    win_valid_s  = 1'b0;
    win_s        = 1'b0;
    owner_lock_s = last_grant_q ? m1_lock : m0_lock;
    if (reset && (state_q == ST_IDLE)) begin
      if (m0_req && m1_req) begin
        win_valid_s = 1'b1;
        // The owner keeps the bus only while locked and under the lock budget.
        if (owner_lock_s && (lock_cnt_q < LOCK_MAX_C)) begin
          win_s = last_grant_q;
        end else begin
          win_s = ~last_grant_q;
        end
      end else if (m0_req) begin
        win_valid_s = 1'b1;
        win_s       = 1'b0;
      end else if (m1_req) begin
        win_valid_s = 1'b1;
        win_s       = 1'b1;
      end else begin
        win_valid_s = 1'b0;
      end
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Mux the winning master's access attributes.
  always_comb begin
    win_lock_s  = win_s ? m1_lock  : m0_lock;
    win_we_s    = win_s ? m1_we    : m0_we;
    win_addr_s  = win_s ? m1_addr  : m0_addr;
    win_wdata_s = win_s ? m1_wdata : m0_wdata;
  end

  assign m0_gnt       = win_valid_s & ~win_s;
  assign m1_gnt       = win_valid_s &  win_s;
  assign enable       = win_valid_s;
  assign write        = win_valid_s ? win_we_s    : 4'h0;
  assign DATA_address = win_valid_s ? win_addr_s  : 32'h0000_0000;
  assign DATA_out     = win_valid_s ? win_wdata_s : 32'h0000_0000;
  assign m0_rvalid    = m0_rvalid_q;
  assign m1_rvalid    = m1_rvalid_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;

  // Next-state: lock bookkeeping on grants, read-return sequencing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rd_owner_d   = rd_owner_q;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    if (win_valid_s) begin
      last_grant_d = win_s;
      if ((win_s == last_grant_q) && win_lock_s) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? LOCK_MAX_C : (lock_cnt_q + LOCK_ONE_C);
      end else if (win_lock_s) begin
        lock_cnt_d = LOCK_ONE_C;
      end else begin
        lock_cnt_d = {LCW{1'b0}};
      end
    end else begin
      last_grant_d = last_grant_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (win_valid_s && (win_we_s == 4'h0)) begin
          state_d    = ST_WAIT_RD;
          rd_cnt_d   = RD_LAT_C;
          rd_owner_d = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        // Slave data is on DATA_in in the last counted cycle; rvalid follows.
        if (rd_cnt_q == 3'd1) begin
          state_d  = ST_IDLE;
          rd_cnt_d = 3'd0;
          if (rd_owner_q) begin
            m1_rvalid_d = 1'b1;
            m1_rdata_d  = DATA_in;
          end else begin
            m0_rvalid_d = 1'b1;
            m0_rdata_d  = DATA_in;
          end
        end else begin
          rd_cnt_d = rd_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= {LCW{1'b0}};
      rd_cnt_q     <= 3'd0;
      rd_owner_q   <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_rdata_q   <= 32'h0000_0000;
      m1_rdata_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_owner_q   <= rd_owner_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Randomized and directed bench for data_port_arbiter, checked every cycle
// against a cycle-indexed transaction model of the arbitration rules.
module tb_data_port_arbiter;

  localparam int RD_LAT = 3;
  localparam int LMAX   = 16;

  localparam int MODE_IDLE = 0;
  localparam int MODE_RAND = 1;
  localparam int MODE_ALT  = 2;
  localparam int MODE_LOCK = 3;
  localparam int MODE_RD   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        enable;
  logic [3:0]  write;
  logic [31:0] DATA_address, DATA_out, DATA_in;

  always #5 clk = ~clk;

  data_port_arbiter #(.RD_LATENCY(RD_LAT), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .enable(enable), .write(write), .DATA_address(DATA_address), .DATA_out(DATA_out),
    .DATA_in(DATA_in)
  );

  int checks = 0;
  int errors = 0;

  // Master-side pending transactions (held until granted).
  bit          req [2];
  bit          lck [2];
  logic [3:0]  we  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  int          mode;

  // Reference model state.
  int          cyc;
  int          busy_until;
  bit          last_m;
  int          streak;
  int          rd_due [$];
  bit          rd_who [$];
  logic [31:0] din_hist [int];
  logic [31:0] exp_rdata [2];

  // Phase bookkeeping from observed grants.
  int prev_win, same_cnt, run_m1, max_run_m1, m0_wins;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic new_txn(input int m);
    adr[m] = $urandom;
    wd[m]  = $urandom;
    case (mode)
      MODE_RAND: begin
        req[m] = ($urandom_range(0, 3) != 0);
        lck[m] = $urandom_range(0, 1) == 1;
        we[m]  = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      MODE_ALT:  begin req[m] = 1'b1; lck[m] = 1'b0; we[m] = 4'hF; end
      MODE_LOCK: begin req[m] = 1'b1; lck[m] = (m == 1); we[m] = 4'h3; end
      MODE_RD:   begin req[m] = 1'b1; lck[m] = 1'b0; we[m] = 4'h0; end
      default:   begin req[m] = 1'b0; lck[m] = 1'b0; we[m] = 4'h0; end
    endcase
  endtask

  task automatic drive_inputs();
    m0_req = req[0]; m0_lock = lck[0]; m0_we = we[0]; m0_addr = adr[0]; m0_wdata = wd[0];
    m1_req = req[1]; m1_lock = lck[1]; m1_we = we[1]; m1_addr = adr[1]; m1_wdata = wd[1];
  endtask

  task automatic model_reset();
    last_m = 1'b1;
    streak = 0;
    busy_until = 0;
    rd_due.delete();
    rd_who.delete();
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
  endtask

  // One clock cycle: drive after the edge, predict and compare at the falling edge.
  task automatic step();
    bit have, w, rv0, rv1;
    int obs_win;
    @(posedge clk); #1;
    drive_inputs();
    DATA_in = $urandom;
    din_hist[cyc] = DATA_in;
    @(negedge clk);

    have = 1'b0; w = 1'b0;
    if (cyc >= busy_until) begin
      if (req[0] && req[1]) begin
        have = 1'b1;
        w = (lck[last_m] && streak < LMAX) ? last_m : !last_m;
      end else if (req[0]) begin
        have = 1'b1; w = 1'b0;
      end else if (req[1]) begin
        have = 1'b1; w = 1'b1;
      end
    end
    rv0 = 1'b0; rv1 = 1'b0;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      if (rd_who[0]) rv1 = 1'b1; else rv0 = 1'b1;
      exp_rdata[rd_who[0]] = din_hist[cyc - 1];
      void'(rd_due.pop_front());
      void'(rd_who.pop_front());
    end

    check_val("m0_gnt", {31'b0, m0_gnt}, {31'b0, have && !w});
    check_val("m1_gnt", {31'b0, m1_gnt}, {31'b0, have && w});
    check_val("enable", {31'b0, enable}, {31'b0, have});
    check_val("write", {28'b0, write}, {28'b0, have ? we[w] : 4'h0});
    check_val("DATA_address", DATA_address, have ? adr[w] : 32'h0);
    check_val("DATA_out", DATA_out, have ? wd[w] : 32'h0);
    check_val("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, rv0});
    check_val("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, rv1});
    check_val("m0_rdata", m0_rdata, exp_rdata[0]);
    check_val("m1_rdata", m1_rdata, exp_rdata[1]);

    obs_win = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
    if (obs_win >= 0) begin
      if (obs_win == prev_win) same_cnt++;
      prev_win = obs_win;
      if (obs_win == 1) run_m1++;
      else begin
        if (run_m1 > max_run_m1) max_run_m1 = run_m1;
        run_m1 = 0;
        m0_wins++;
      end
    end

    if (have) begin
      if (w == last_m && lck[w]) streak = (streak < LMAX) ? streak + 1 : LMAX;
      else streak = lck[w] ? 1 : 0;
      last_m = w;
      if (we[w] == 4'h0) begin
        busy_until = cyc + RD_LAT + 1;
        rd_due.push_back(cyc + RD_LAT + 1);
        rd_who.push_back(w);
      end
      new_txn(w);
    end
    for (int m = 0; m < 2; m++) begin
      if (!(have && w == m)) begin
        if (req[m] && mode == MODE_RAND && $urandom_range(0, 19) == 0) req[m] = 1'b0;
        else if (!req[m]) new_txn(m);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int md);
    mode = md;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_stats();
    prev_win = -1; same_cnt = 0; run_m1 = 0; max_run_m1 = 0; m0_wins = 0;
  endtask

  // Hold reset for n cycles with both masters requesting; all outputs must be 0.
  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b1; lck[m] = 1'b0; we[m] = 4'hF; adr[m] = $urandom; wd[m] = $urandom;
    end
    drive_inputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'h0);
      check_val("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
      check_val("rst_enable", {27'b0, enable, write}, 32'h0);
      check_val("rst_addr", DATA_address, 32'h0);
      check_val("rst_dout", DATA_out, 32'h0);
      check_val("rst_rdata0", m0_rdata, 32'h0);
      check_val("rst_rdata1", m1_rdata, 32'h0);
      @(posedge clk); #1;
    end
    for (int m = 0; m < 2; m++) req[m] = 1'b0;
    drive_inputs();
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0;
    DATA_in = 32'h0;
    mode = MODE_IDLE;
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; lck[m] = 1'b0; we[m] = 4'h0; adr[m] = 32'h0; wd[m] = 32'h0;
    end
    drive_inputs();
    clear_stats();
    model_reset();
    do_reset(3);

    // Single m0 write, seen on the slave port in the grant cycle.
    mode = MODE_IDLE;
    req[0] = 1'b1; lck[0] = 1'b0; we[0] = 4'hF; adr[0] = 32'h100; wd[0] = 32'hDEADBEEF;
    step();
    check_val("wr_gnt_en", {30'b0, m0_gnt, enable}, 32'h3);
    check_val("wr_addr", DATA_address, 32'h100);
    check_val("wr_data", DATA_out, 32'hDEADBEEF);
    run(4, MODE_IDLE);

    // After reset both request reads together: m0 first, then m1 after the return.
    do_reset(2);
    mode = MODE_RD;
    new_txn(0); new_txn(1);
    step();
    check_val("post_rst_first_m0", {30'b0, m1_gnt, m0_gnt}, 32'h1);
    run(15, MODE_RD);
    run(8, MODE_IDLE);

    // Unlocked continuous writes must alternate.
    clear_stats();
    run(20, MODE_ALT);
    check_val("alt_no_repeat", same_cnt, 0);
    run(6, MODE_IDLE);

    // m1 locked: runs of exactly LMAX grants broken by one m0 grant.
    clear_stats();
    run(60, MODE_LOCK);
    if (run_m1 > max_run_m1) max_run_m1 = run_m1;
    check_val("lock_run_len", max_run_m1, LMAX);
    check_val("lock_m0_got_turn", (m0_wins >= 2) ? 1 : 0, 1);
    run(6, MODE_IDLE);

    // m0 read at T, m1 request from T+1: blocked until the return at T+4.
    req[0] = 1'b1; lck[0] = 1'b0; we[0] = 4'h0; adr[0] = 32'h40;
    step();
    check_val("lat_rd_gnt", {31'b0, m0_gnt}, 32'h1);
    req[1] = 1'b1; lck[1] = 1'b0; we[1] = 4'hF; adr[1] = 32'h80; wd[1] = 32'h1234_5678;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_val("lat_m1_blocked", {31'b0, m1_gnt}, 32'h0);
    end
    step();
    check_val("lat_rv_and_gnt", {30'b0, m0_rvalid, m1_gnt}, 32'h3);
    run(6, MODE_IDLE);

    // Reset during an outstanding read drops it; no rvalid afterwards.
    req[0] = 1'b1; lck[0] = 1'b0; we[0] = 4'h0; adr[0] = 32'h44;
    step();
    check_val("midrst_rd_gnt", {31'b0, m0_gnt}, 32'h1);
    do_reset(2);
    run(8, MODE_IDLE);

    run(2000, MODE_RAND);
    run(10, MODE_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
